// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: access sequencer between the LC-3 control FSM and memory/devices.
// Memory accesses run through an enable/ready handshake with a timeout abort.
// KBSR/KBDR/DSR/DDR are serviced locally, and a one-cycle o_ready strobe marks
// each completion.
// Optional feature macro: MEM_IO_INT_EN (writable IE bits plus a registered o_irq).
module mem_io_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_req,
  input  logic        i_rw,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_ready,
  output logic        o_mem_en,
  output logic        o_mem_rw,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_r,
  input  logic        i_kbd_valid,
  input  logic [7:0]  i_kbd_data,
  output logic        o_dsp_valid,
  output logic [7:0]  o_dsp_data,
  input  logic        i_dsp_ready,
  output logic        o_timeout,
  output logic        o_irq
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] DEV_BASE  = 16'hFE00;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, IO, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_nxt;
  logic             kb_ready;
  logic [7:0]       kbdr;
  logic             dsr_ready;
  logic [7:0]       ddr;
  logic             kb_ie;
  logic             dsr_ie;
  logic [15:0]      dev_rdata;
  logic             io_rd;
  logic             io_wr;
  logic             kbdr_rd;
  logic             ddr_wr;

  // The latched address/direction double as the device-register selector in IO.
  assign io_rd   = (state == IO) && !o_mem_rw;
  assign io_wr   = (state == IO) &&  o_mem_rw;
  assign kbdr_rd = io_rd && (o_mem_addr == ADDR_KBDR);
  assign ddr_wr  = io_wr && (o_mem_addr == ADDR_DDR);
  assign tmo_nxt = tmo_cnt + 1'b1;

  assign o_dsp_data = ddr;

  // Device register read mux; unmapped device addresses read as zero.
  always_comb begin
    dev_rdata = 16'h0000;
    case (o_mem_addr)
      ADDR_KBSR: dev_rdata = {kb_ready, kb_ie, 14'h0000};
      ADDR_KBDR: dev_rdata = {8'h00, kbdr};
      ADDR_DSR:  dev_rdata = {dsr_ready, dsr_ie, 14'h0000};
      ADDR_DDR:  dev_rdata = {8'h00, ddr};
      default:   dev_rdata = 16'h0000;
    endcase
  end

  // Access sequencer: latch request, run memory handshake or IO cycle, strobe completion.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      o_ready     <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_rw    <= 1'b0;
      o_mem_addr  <= 16'h0000;
      o_mem_wdata <= 16'h0000;
      o_rdata     <= 16'h0000;
      o_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_ready <= 1'b0;
          if (i_req) begin
            o_mem_rw    <= i_rw;
            o_mem_addr  <= i_addr;
            o_mem_wdata <= i_wdata;
            tmo_cnt     <= '0;
            if (i_addr >= DEV_BASE) begin
              state <= IO;
            end else begin
              state    <= MEM_WAIT;
              o_mem_en <= 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          tmo_cnt <= tmo_nxt;
          // A ready arriving on the abort edge still completes normally.
          if (i_mem_r) begin
            if (!o_mem_rw) o_rdata <= i_mem_rdata;
            o_mem_en <= 1'b0;
            o_ready  <= 1'b1;
            state    <= DONE;
          end else if (tmo_nxt == CNT_W'(TIMEOUT)) begin
            o_timeout <= 1'b1;
            o_rdata   <= 16'h0000;
            o_mem_en  <= 1'b0;
            o_ready   <= 1'b1;
            state     <= DONE;
          end
        end
        IO: begin
          if (!o_mem_rw) o_rdata <= dev_rdata;
          o_ready <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          o_ready  <= 1'b0;
          o_mem_en <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Keyboard input: capture when empty or when a KBDR read frees the slot this cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      kb_ready <= 1'b0;
      kbdr     <= 8'h00;
    end else if (i_kbd_valid && (!kb_ready || kbdr_rd)) begin
      kbdr     <= i_kbd_data;
      kb_ready <= 1'b1;
    end else if (kbdr_rd) begin
      kb_ready <= 1'b0;
    end
  end

  // Display output: DDR write launches a character, display acceptance frees DSR.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      dsr_ready   <= 1'b1;
      ddr         <= 8'h00;
      o_dsp_valid <= 1'b0;
    end else if (ddr_wr && dsr_ready) begin
      ddr         <= o_mem_wdata[7:0];
      dsr_ready   <= 1'b0;
      o_dsp_valid <= 1'b1;
    end else if (o_dsp_valid && i_dsp_ready) begin
      o_dsp_valid <= 1'b0;
      dsr_ready   <= 1'b1;
    end
  end

`ifdef MEM_IO_INT_EN
  logic kbsr_wr;
  logic dsr_wr;

  assign kbsr_wr = io_wr && (o_mem_addr == ADDR_KBSR);
  assign dsr_wr  = io_wr && (o_mem_addr == ADDR_DSR);

  // Interrupt enables (bit14 of KBSR/DSR) and the registered interrupt request.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      kb_ie  <= 1'b0;
      dsr_ie <= 1'b0;
      o_irq  <= 1'b0;
    end else begin
      if (kbsr_wr) kb_ie  <= o_mem_wdata[14];
      if (dsr_wr)  dsr_ie <= o_mem_wdata[14];
      o_irq <= (kb_ready & kb_ie) | (dsr_ready & dsr_ie);
    end
  end
`else
  assign kb_ie  = 1'b0;
  assign dsr_ie = 1'b0;
  assign o_irq  = 1'b0;
`endif

endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Sequencer between the LC-3 control FSM and the memory/device space. It accepts one access at a time, runs memory accesses through the `MEMORY` enable/ready handshake, and services memory-mapped device registers locally: KBSR, KBDR, DSR and DDR. It returns a single-cycle completion strobe to the control FSM. It owns the keyboard-input and display-output handshakes.

## Interface
- TIMEOUT, 8: max cycles in MEM_WAIT without memory ready before abort (≥2)
- i_Clk  in  1  clock, all state on rising edge
- i_Rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  access request; sampled only in IDLE
- i_rw  in  1  1 = write, 0 = read
- i_addr  in  16  access address (MAR)
- i_wdata  in  16  write data (MDR)
- o_rdata  out  16  read result; valid while o_ready = 1, held until next completion
- o_ready  out  1  one-cycle completion pulse
- o_mem_en, o_mem_rw  out  1 each  memory enable / direction
- o_mem_addr, o_mem_wdata  out  16 each  latched address / data to memory
- i_mem_rdata  in  16  memory read data
- i_mem_r  in  1  memory done
- i_kbd_valid  in  1  keyboard character strobe
- i_kbd_data  in  8  character
- o_dsp_valid  out  1  display character pending
- o_dsp_data  out  8  DDR[7:0]
- i_dsp_ready  in  1  display accepts character
- o_timeout  out  1  sticky: a memory access timed out
- o_irq  out  1  device interrupt request

## Operation
- Device map:
  - xFE00 KBSR
  - xFE02 KBDR
  - xFE04 DSR
  - xFE06 DDR
- Other addresses ≥ xFE00 are unmapped devices: reads return 0, writes are ignored. Addresses < xFE00 are memory.
- FSM states IDLE, MEM_WAIT, IO, DONE.
  - IDLE: on i_req, latch i_rw, i_addr and i_wdata. Device address → IO. Memory address → MEM_WAIT.
  - MEM_WAIT:
    - o_mem_en = 1, with o_mem_rw/addr/wdata from the latched values.
    - On i_mem_r: a read captures i_mem_rdata into o_rdata; go to DONE.
    - If i_mem_r has not arrived after TIMEOUT cycles in MEM_WAIT: set o_timeout, o_rdata = 0, go to DONE.
  - IO: one cycle; perform the register read/write; go to DONE.
  - DONE: o_ready = 1, o_mem_en = 0; go to IDLE.
- Write-only completion: o_rdata is unchanged on writes.
- KBSR:
  - bit15 = ready, bit14 = IE, other bits read 0.
  - i_kbd_valid with ready = 0: KBDR[7:0] ← i_kbd_data, set ready.
  - i_kbd_valid with ready = 1: character dropped.
- KBDR read returns {8'h00, KBDR[7:0]} and clears ready.
  - If the clearing read coincides with i_kbd_valid: the read returns the old data, the new character is captured, and ready ends at 1.
- DSR: bit15 = ready (reset 1), bit14 = IE.
- DDR write:
  - With DSR ready = 1: DDR ← wdata[7:0], ready ← 0, o_dsp_valid ← 1.
  - With ready = 0: write ignored.
- Display handshake: when o_dsp_valid & i_dsp_ready on an edge, o_dsp_valid ← 0 and DSR ready ← 1.
- Writes to KBSR/DSR affect bit14 only. Writes to KBDR are ignored.
- Reads of DDR return {8'h00, DDR}.

## Timing
- Reset values:
  - State IDLE.
  - o_ready, o_mem_en, o_mem_rw, o_dsp_valid, o_timeout, o_irq = 0.
  - o_rdata, o_mem_addr, o_mem_wdata, o_dsp_data = 0.
  - KBSR = 0, KBDR = 0, DSR = x8000, DDR = 0.
- Reset mid-access: the access is abandoned and o_mem_en drops immediately (async). No o_ready is produced.
- Memory access: i_req sampled at edge N → o_mem_en high from N. i_mem_r seen at edge M → o_ready high during the cycle after M.
- Minimum memory access: 3 edges from request to completion.
- IO access: i_req sampled at edge N → IO state, o_ready high during the cycle after edge N+1.
- Back-to-back requests: the requester must drop i_req or present the next access when o_ready is seen. IDLE samples i_req at the edge after DONE; one idle cycle exists between accesses.
- Timeout counter: $clog2(TIMEOUT+1) bits, cleared on entry to MEM_WAIT. Abort on the edge where the count reaches TIMEOUT with i_mem_r = 0. i_mem_r on that same edge wins: no timeout.
- Keyboard and display handshakes run every cycle, independent of FSM state.

## Configuration
- MEM_IO_INT_EN defined:
  - KBSR[14] and DSR[14] are writable.
  - o_irq = (KBSR[15] & KBSR[14]) | (DSR[15] & DSR[14]), registered, so it follows status by one cycle.
- MEM_IO_INT_EN undefined:
  - Bit14 of both registers reads 0 and writes to it are ignored.
  - o_irq is tied to 0.

## Test plan
- Memory read x3000, memory asserts i_mem_r 2 cycles after o_mem_en → o_rdata = memory word, exactly one o_ready pulse, o_mem_en low in DONE.
- Memory write x0010 with i_mem_r never asserted, TIMEOUT = 8 → o_ready after 8 MEM_WAIT cycles, o_timeout = 1 and stays 1 until reset.
- Keyboard:
  - i_kbd_valid with x41 → KBSR read = x8000.
  - KBDR read = x0041, then KBSR read = x0000.
  - Second character while ready = 1 is dropped.
- Display:
  - Write DDR x0048 → o_dsp_valid = 1, o_dsp_data = x48, DSR = x0000.
  - Second DDR write ignored.
  - i_dsp_ready → DSR = x8000.
- With MEM_IO_INT_EN: write KBSR x4000, then a keyboard character → o_irq = 1. Without the macro, o_irq stays 0 and KBSR reads x8000.
- Assert i_Rst_n low in MEM_WAIT → o_mem_en = 0 at once, no o_ready, DSR = x8000 after reset.
